// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a level read handshake on the bus
// and strobes the fetched word into the IR. Optional bus timeout: CPU_FETCH_TIMEOUT_EN.
module cpu_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pc_load,
  input  logic [31:0] pc_new,
  input  logic        pc_inc,
  input  logic        fault_clr,
  output logic [31:0] bus_addr,
  output logic        bus_rd,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] ir_data,
  output logic        ir_wr,
  output logic [31:0] pc,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_MISALGN = 2'b01;
`ifdef CPU_FETCH_TIMEOUT_EN
  localparam logic [1:0]  FC_TMO    = 2'b10;
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
`endif

  state_t      state_q;
  logic [31:0] pc_q;
  logic        bus_rd_q;
  logic        done_q;
  logic [1:0]  fcode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      bus_rd_q <= 1'b0;
      done_q   <= 1'b0;
      fcode_q  <= FC_NONE;
`ifdef CPU_FETCH_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Any PC update in the same cycle swallows start.
          if (pc_load)       pc_q <= pc_new;
          else if (pc_inc)   pc_q <= pc_q + 32'd4;
          else if (start) begin
            if (pc_q[1:0] != 2'b00) begin
              state_q <= S_FAULT;
              fcode_q <= FC_MISALGN;
            end else begin
              state_q  <= S_REQ;
              bus_rd_q <= 1'b1;
`ifdef CPU_FETCH_TIMEOUT_EN
              cnt_q    <= '0;
`endif
            end
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            state_q  <= S_DONE;
            bus_rd_q <= 1'b0;
            done_q   <= 1'b1;
          end
`ifdef CPU_FETCH_TIMEOUT_EN
          else if (cnt_q == TMO_LAST) begin
            state_q  <= S_FAULT;
            bus_rd_q <= 1'b0;
            fcode_q  <= FC_TMO;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        S_DONE: state_q <= S_IDLE;
        S_FAULT: begin
          if (fault_clr) begin
            state_q <= S_IDLE;
            fcode_q <= FC_NONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // IR write is a same-cycle pass-through of the bus ack while requesting.
  assign ir_wr      = (state_q == S_REQ) && bus_ack;
  assign ir_data    = ir_wr ? bus_rdata : 32'h0;
  assign bus_addr   = pc_q;
  assign bus_rd     = bus_rd_q;
  assign pc         = pc_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign fault      = (state_q == S_FAULT);
  assign fault_code = fcode_q;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Randomized transaction-level bench for cpu_fetch_unit; the model tracks only
// the architectural PC and derives every expected output from the fetch rules.
module tb_cpu_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0, rst = 1'b0;
  logic        start = 0, pc_load = 0, pc_inc = 0, fault_clr = 0, bus_ack = 0;
  logic [31:0] pc_new = 0, bus_rdata = 0;
  logic [31:0] bus_addr, ir_data, pc;
  logic        bus_rd, ir_wr, busy, done, fault;
  logic [1:0]  fault_code;

  int n_vec = 0, n_err = 0;
  logic [31:0] mpc;

  cpu_fetch_unit #(.RESET_PC(RPC), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pc_load(pc_load), .pc_new(pc_new),
    .pc_inc(pc_inc), .fault_clr(fault_clr), .bus_addr(bus_addr), .bus_rd(bus_rd),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .ir_data(ir_data), .ir_wr(ir_wr),
    .pc(pc), .busy(busy), .done(done), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_in();
    start = 0; pc_load = 0; pc_inc = 0; fault_clr = 0; bus_ack = 0;
  endtask

  // Full fetch from an aligned PC with w wait cycles before the ack.
  task automatic do_fetch(input int w, input logic [31:0] rd);
    start = 1; tick(); start = 0;
    chk("req_rd", bus_rd, 1); chk("req_addr", bus_addr, mpc); chk("req_busy", busy, 1);
    for (int i = 0; i < w; i++) begin
      pc_load = 1'($urandom); pc_new = $urandom; pc_inc = 1'($urandom); start = 1'($urandom);
      #1 chk("wait_irwr", ir_wr, 0);
      tick();
      chk("wait_rd", bus_rd, 1); chk("wait_pc", pc, mpc); chk("wait_done", done, 0);
    end
    clr_in();
    bus_ack = 1; bus_rdata = rd;
    #1 chk("ack_irwr", ir_wr, 1); chk("ack_irdata", ir_data, rd);
    tick(); bus_ack = 0;
    chk("done_pulse", done, 1); chk("done_rd", bus_rd, 0);
    chk("done_irwr", ir_wr, 0); chk("done_irdata", ir_data, 0); chk("done_busy", busy, 1);
    tick();
    chk("post_done", done, 0); chk("post_busy", busy, 0); chk("post_pc", pc, mpc);
  endtask

  // Load a misaligned PC, start, then hold in FAULT and clear.
  task automatic do_fault(input logic [31:0] a);
    pc_load = 1; pc_new = a; tick(); pc_load = 0; mpc = a;
    chk("mis_pc", pc, mpc);
    start = 1; #1 chk("mis_rd0", bus_rd, 0);
    tick(); start = 0;
    chk("flt", fault, 1); chk("flt_code", fault_code, 1); chk("flt_rd", bus_rd, 0);
    chk("flt_busy", busy, 1);
    for (int i = 0; i < 2; i++) begin
      start = 1; pc_inc = 1; pc_load = 1; pc_new = $urandom;
      tick();
      chk("flt_hold_pc", pc, mpc); chk("flt_hold", fault, 1); chk("flt_hold_rd", bus_rd, 0);
    end
    clr_in(); fault_clr = 1; tick(); fault_clr = 0;
    chk("clr_flt", fault, 0); chk("clr_code", fault_code, 0);
    chk("clr_pc", pc, mpc); chk("clr_busy", busy, 0);
  endtask

  task automatic realign();
    if (mpc[1:0] != 2'b00) begin
      pc_load = 1; pc_new = $urandom & 32'hFFFF_FFFC; mpc = pc_new;
      tick(); pc_load = 0;
    end
  endtask

  initial begin
    int w, op;
    logic [31:0] a;
    rst = 1; #12; rst = 0; #1;
    mpc = RPC;
    chk("rst_pc", pc, RPC); chk("rst_addr", bus_addr, RPC); chk("rst_rd", bus_rd, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0); chk("rst_irwr", ir_wr, 0);
    @(negedge clk); tick();

    do_fetch(3, 32'h0000_0293);

    pc_inc = 1; tick(); pc_inc = 0; mpc += 4;
    chk("inc_pc", pc, 32'h104);
    pc_load = 1; pc_new = 32'h2000; pc_inc = 1; start = 1;
    tick(); clr_in(); mpc = 32'h2000;
    chk("ld_pc", pc, 32'h2000); chk("ld_rd", bus_rd, 0); chk("ld_busy", busy, 0);
    do_fetch(1, 32'hDEAD_BEEF);

    do_fault(32'h2002);

    pc_load = 1; pc_new = 32'hFFFF_FFFC; tick(); pc_load = 0;
    pc_inc = 1; tick(); pc_inc = 0; mpc = 0;
    chk("wrap_pc", pc, 0);

    // Asynchronous reset in the middle of a request.
    start = 1; tick(); start = 0;
    chk("mid_rd", bus_rd, 1);
    #2 rst = 1; #1;
    chk("arst_rd", bus_rd, 0); chk("arst_pc", pc, RPC); chk("arst_busy", busy, 0);
    mpc = RPC;
    @(posedge clk); #2 rst = 0;
    bus_ack = 1; bus_rdata = 32'h1234_5678;
    #1 chk("arst_irwr", ir_wr, 0);
    tick(); bus_ack = 0;
    chk("arst_done", done, 0); chk("arst_busy2", busy, 0);

`ifdef CPU_FETCH_TIMEOUT_EN
    start = 1; tick(); start = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("tmo_rd_pre", bus_rd, 1); chk("tmo_flt_pre", fault, 0);
    tick();
    chk("tmo_flt", fault, 1); chk("tmo_code", fault_code, 2); chk("tmo_rd", bus_rd, 0);
    chk("tmo_irwr", ir_wr, 0); chk("tmo_pc", pc, mpc);
    fault_clr = 1; tick(); fault_clr = 0;
    chk("tmo_clr", fault_code, 0);
    start = 1; tick(); start = 0;
    for (int i = 0; i < 3; i++) tick();
    bus_ack = 1; bus_rdata = 32'hCAFE_0001;
    #1 chk("tmo_ack_irwr", ir_wr, 1);
    tick(); bus_ack = 0;
    chk("tmo_ack_done", done, 1); chk("tmo_ack_flt", fault, 0);
    tick();
`else
    start = 1; tick(); start = 0;
    for (int i = 0; i < 300; i++) tick();
    chk("notmo_rd", bus_rd, 1); chk("notmo_flt", fault, 0);
    bus_ack = 1; bus_rdata = 32'hCAFE_0001;
    #1 chk("notmo_irwr", ir_wr, 1);
    tick(); bus_ack = 0;
    chk("notmo_done", done, 1);
    tick();
`endif

    for (int it = 0; it < 50; it++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          realign();
`ifdef CPU_FETCH_TIMEOUT_EN
          w = int'($urandom_range(0, 2));
`else
          w = int'($urandom_range(0, 6));
`endif
          do_fetch(w, $urandom);
        end
        1: begin
          a = $urandom;
          if (a[1:0] == 2'b00) a[0] = 1'b1;
          do_fault(a);
        end
        2: begin
          pc_load = 1'($urandom); pc_inc = 1'($urandom); start = 1'($urandom);
          if (!pc_load && !pc_inc) pc_inc = 1;
          pc_new = $urandom;
          if (pc_load) mpc = pc_new; else mpc = mpc + 32'd4;
          tick(); clr_in();
          chk("upd_pc", pc, mpc); chk("upd_busy", busy, 0); chk("upd_rd", bus_rd, 0);
        end
        default: begin
          bus_ack = 1; bus_rdata = $urandom;
          #1 chk("idle_ack_irwr", ir_wr, 0); chk("idle_ack_data", ir_data, 0);
          tick(); bus_ack = 0;
          chk("idle_ack_busy", busy, 0); chk("idle_ack_pc", pc, mpc);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
